bcd_subtractor8_serial: RTL

Digit-serial packed-BCD subtractor and the inverse of the team's combinational 2-digit BCD adder. It computes `diff = a - b - bin` in ten's-complement BCD, one decimal digit per clock, least-significant digit first. A valid/ready handshake sits on each side, so the block can go in a pipelined decimal datapath behind operand registers and ahead of a result FIFO.

---
 rtl/bcd_pkg.sv | 25 ++
 rtl/bcd_digit_sub.sv | 14 +
 rtl/bcd_subtractor8_serial.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD types, radix constant and single-digit subtract helper
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } bcd_sub_state_t;

   localparam int BCD_RADIX = 10;

   // Returns {borrow_out, digit}; a negative 5-bit difference is folded back by the radix.
   function automatic logic [4:0] bcd_digit_sub(input logic [3:0] a4,
                                                input logic [3:0] b4,
                                                input logic       br);
      logic [4:0] t;
      t = {1'b0, a4} - {1'b0, b4} - {4'b0000, br};
      if (t[4]) begin
         bcd_digit_sub = {1'b1, t[3:0] + 4'(BCD_RADIX)};
      end else begin
         bcd_digit_sub = {1'b0, t[3:0]};
      end
   endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// rtl/bcd_digit_sub.sv - combinational single-digit BCD subtract stage
module bcd_digit_sub (
   input  logic [3:0] a4,
   input  logic [3:0] b4,
   input  logic       br_in,
   output logic [3:0] d4,
   output logic       br_out
);

   always_comb begin
      {br_out, d4} = bcd_pkg::bcd_digit_sub(a4, b4, br_in);
   end

endmodule

// File: rtl/bcd_subtractor8_serial.sv
// rtl/bcd_subtractor8_serial.sv - digit-serial packed-BCD subtractor, LSD first; BCD_CHECK_EN adds err
module bcd_subtractor8_serial
   import bcd_pkg::*;
#(
   parameter int DIGITS = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [4*DIGITS-1:0] a,
   input  logic [4*DIGITS-1:0] b,
   input  logic                bin,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [4*DIGITS-1:0] diff,
   output logic                bout,
   output logic                out_valid,
   input  logic                out_ready
`ifdef BCD_CHECK_EN
   ,
   output logic                err
`endif
);

   localparam int W  = 4 * DIGITS;
   localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(DIGITS - 1);

   bcd_sub_state_t state_q, state_d;
   logic [KW-1:0]  k_q, k_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic           br_q, br_d;
   logic [W-1:0]   diff_q, diff_d;
   logic           bout_q, bout_d;
   logic           in_ready_q, in_ready_d;
   logic           out_valid_q, out_valid_d;

   logic [3:0]     dig_d4;
   logic           dig_br;

   // Operands shift right each CALC cycle, so the active digit is always in [3:0].
   bcd_digit_sub u_digit (
      .a4     (a_q[3:0]),
      .b4     (b_q[3:0]),
      .br_in  (br_q),
      .d4     (dig_d4),
      .br_out (dig_br)
   );

`ifdef BCD_CHECK_EN
   logic err_q, err_d;
   logic bad_nibble;

   always_comb begin
      bad_nibble = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) begin
            bad_nibble = 1'b1;
         end
      end
   end
`endif

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      a_d         = a_q;
      b_d         = b_q;
      br_d        = br_q;
      diff_d      = diff_q;
      bout_d      = bout_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
`ifdef BCD_CHECK_EN
      err_d       = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               a_d        = a;
               b_d        = b;
               br_d       = bin;
               diff_d     = '0;
               k_d        = '0;
               in_ready_d = 1'b0;
               state_d    = CALC;
`ifdef BCD_CHECK_EN
               err_d      = bad_nibble;
`endif
            end
         end
         CALC: begin
            a_d    = a_q >> 4;
            b_d    = b_q >> 4;
            br_d   = dig_br;
            diff_d = (diff_q >> 4) | (W'(dig_d4) << (W - 4));
            if (k_q == K_LAST) begin
               bout_d      = dig_br;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d     = IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         k_q         <= '0;
         a_q         <= '0;
         b_q         <= '0;
         br_q        <= 1'b0;
         diff_q      <= '0;
         bout_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef BCD_CHECK_EN
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         a_q         <= a_d;
         b_q         <= b_d;
         br_q        <= br_d;
         diff_q      <= diff_d;
         bout_q      <= bout_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
`ifdef BCD_CHECK_EN
         err_q       <= err_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign diff      = diff_q;
   assign bout      = bout_q;
`ifdef BCD_CHECK_EN
   assign err       = err_q;
`endif

endmodule
